mem_stage_ctrl: RTL and testbench

Sequencer for the MEM stage of the 5-stage pipeline when data memory is multi-cycle. It watches the MEM control bits and operands held in the EX/MEM pipeline register, and drives a req/ack handshake to data memory. It holds the pipeline frozen with `stall_o` until the access completes, then presents load data to MEM/WB. A wait-cycle watchdog flags a memory that never acknowledges.

---
 rtl/mem_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: runs a req/ack handshake to multi-cycle data memory,
// stalls the pipeline until completion and flags a memory that never answers.
//
// state | meaning
// IDLE  | waiting for a load/store in EX/MEM
// REQ   | request outstanding, counting wait cycles
// DONE  | one-cycle completion slot; pipeline advances at its end
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        err_o
);

    localparam logic [15:0] L_CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_timed_out;

    logic        w_access;
    logic        w_cnt_last;
    logic        w_req;
    logic        w_stall;
    logic        w_rvalid;

    assign w_access   = MemRead_i | MemWrite_i;
    assign w_cnt_last = (r_cnt == L_CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_stall  = 1'b0;
        w_rvalid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_access;
                if (w_access) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (mem_ack_i || w_cnt_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_rvalid = ~r_we & ~r_timed_out;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operands latch on REQ entry and stay put until DONE exits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_timed_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_addr      <= addr_i;
                        r_wdata     <= wdata_i;
                        r_we        <= MemWrite_i;
                        r_cnt       <= '0;
                        r_timed_out <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                    end else if (w_cnt_last) begin
                        r_err       <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_rdata     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req_o     = w_req;
    assign mem_we_o      = r_we;
    assign mem_addr_o    = r_addr;
    assign mem_wdata_o   = r_wdata;
    assign stall_o       = w_stall;
    assign rdata_o       = r_rdata;
    assign rdata_valid_o = w_rvalid;
    assign err_o         = r_err;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random transactions
// checked against a transaction-level expectation model.
module tb_mem_stage_ctrl;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        err_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] exp_rdata;
    logic        exp_err;

    mem_stage_ctrl #(.TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full transaction starting in an IDLE cycle; k = cycle of the ack
    // (k > TO means the memory never answers). Inputs stay held through DONE.
    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int k, input logic [31:0] rdat);
        logic timed_out;
        logic exp_we;
        int   nreq;
        timed_out = (k > int'(TO));
        nreq      = timed_out ? int'(TO) : k;
        exp_we    = wr;
        MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = d;
        mem_ack_i = 1'b0;
        @(negedge clk_i);
        chk("idle_stall", 32'(stall_o), 32'd1);
        chk("idle_req", 32'(mem_req_o), 32'd0);
        for (int c = 1; c <= nreq; c++) begin
            @(posedge clk_i); #1;
            mem_ack_i   = (c == k);
            mem_rdata_i = (c == k) ? rdat : $urandom;
            @(negedge clk_i);
            chk("req_req", 32'(mem_req_o), 32'd1);
            chk("req_stall", 32'(stall_o), 32'd1);
            chk("req_we", 32'(mem_we_o), 32'(exp_we));
            chk("req_addr", mem_addr_o, a);
            chk("req_wdata", mem_wdata_o, d);
        end
        @(posedge clk_i); #1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (timed_out) begin
            exp_rdata = 32'd0;
            exp_err   = 1'b1;
        end else if (!wr) begin
            exp_rdata = rdat;
        end
        @(negedge clk_i);
        chk("done_req", 32'(mem_req_o), 32'd0);
        chk("done_stall", 32'(stall_o), 32'd0);
        chk("done_valid", 32'(rdata_valid_o), 32'(!wr && !timed_out));
        chk("done_rdata", rdata_o, exp_rdata);
        chk("done_err", 32'(err_o), 32'(exp_err));
        chk("done_we", 32'(mem_we_o), 32'(exp_we));
        chk("done_addr", mem_addr_o, a);
        @(posedge clk_i); #1;
    endtask

    task automatic idle_cycle(input logic ack);
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
        mem_ack_i = ack; mem_rdata_i = $urandom;
        @(negedge clk_i);
        chk("idle_nostall", 32'(stall_o), 32'd0);
        chk("idle_noreq", 32'(mem_req_o), 32'd0);
        chk("idle_novalid", 32'(rdata_valid_o), 32'd0);
        chk("idle_rdata", rdata_o, exp_rdata);
        @(posedge clk_i); #1;
        mem_ack_i = 1'b0;
    endtask

    initial begin
        logic rd, wr;
        int   k;
        rst_i = 1'b0;
        MemRead_i = 1'b1; MemWrite_i = 1'b0;
        addr_i = 32'hCAFE_0000; wdata_i = 32'h5555_AAAA;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        exp_rdata = 32'd0; exp_err = 1'b0;

        #22;
        chk("rst_req", 32'(mem_req_o), 32'd0);
        chk("rst_we", 32'(mem_we_o), 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_valid", 32'(rdata_valid_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rel_stall", 32'(stall_o), 32'd1);
        chk("rel_req", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rel_req_next", 32'(mem_req_o), 32'd1);
        chk("rel_addr", mem_addr_o, 32'hCAFE_0000);
        // asynchronous reset in the middle of REQ
        #2 rst_i = 1'b0;
        #1;
        chk("async_req_drop", 32'(mem_req_o), 32'd0);
        chk("async_addr", mem_addr_o, 32'd0);
        MemRead_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        do_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF);
        idle_cycle(1'b0);
        do_txn(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1, 32'hFFFF_0000);
        idle_cycle(1'b0);
        // load held through DONE, then a back-to-back load at a new address
        do_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1, 32'h0BAD_F00D);
        do_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 2, 32'h1357_9BDF);
        idle_cycle(1'b0);
        do_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, TO + 5, 32'h0);
        idle_cycle(1'b0);
        do_txn(1'b1, 1'b0, 32'h0000_0084, 32'h0, 2, 32'hA5A5_5A5A);
        idle_cycle(1'b1);
        do_txn(1'b1, 1'b1, 32'h0000_0090, 32'h7777_8888, 2, 32'h1111_2222);
        idle_cycle(1'b1);

        for (int i = 0; i < 30; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            k  = int'($urandom_range(1, TO + 2));
            do_txn(rd, wr, $urandom, $urandom, k, $urandom);
            if ($urandom_range(0, 1) == 1) idle_cycle(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
